// File: rtl/count_seq_ctrl_if.sv
// Command channel of the counter sequencer: valid/ready handshake plus the
// opcode and the run parameters sampled when a START is accepted.
interface count_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_limit;
    logic [DIV_W-1:0] cmd_div;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_limit,
        output cmd_div,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_limit,
        input  cmd_div,
        output cmd_ready
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer for an external up-counter: runs it 0..limit once or looping,
// paced by a prescaler, with pause/resume and abort over a command channel.
module count_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int DIV_W  = 8,
    parameter int LOOP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    count_seq_ctrl_if.slave   cmd,
    input  logic [WIDTH-1:0]  cnt_value,
    output logic              cnt_clr,
    output logic              cnt_inc,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [LOOP_W-1:0] loop_count
);
    localparam logic [1:0] OP_START_ONCE   = 2'b00;
    localparam logic [1:0] OP_START_LOOP   = 2'b01;
    localparam logic [1:0] OP_PAUSE_TOGGLE = 2'b10;
    localparam logic [1:0] OP_ABORT        = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    state_t             state_reg,     state_next;
    logic [DIV_W-1:0]   pre_reg,       pre_next;
    logic [LOOP_W-1:0]  loop_reg,      loop_next;
    logic [WIDTH-1:0]   limit_reg,     limit_next;
    logic [DIV_W-1:0]   div_reg,       div_next;
    logic               loop_mode_reg, loop_mode_next;

    logic accept;
    logic tick;
    logic terminal;

    // Ready is a pure function of state (and reset), never of the command itself.
    assign cmd.cmd_ready = !rst && (state_reg != CLEAR);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    assign tick     = (state_reg == RUN) && (pre_reg == div_reg);
    assign terminal = tick && (cnt_value >= limit_reg);

    assign busy       = (state_reg != IDLE);
    assign paused     = (state_reg == PAUSE);
    assign loop_count = loop_reg;

    always_comb begin
        state_next     = state_reg;
        pre_next       = pre_reg;
        loop_next      = loop_reg;
        limit_next     = limit_reg;
        div_next       = div_reg;
        loop_mode_next = loop_mode_reg;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept && (cmd.cmd_op == OP_START_ONCE || cmd.cmd_op == OP_START_LOOP)) begin
                    limit_next     = cmd.cmd_limit;
                    div_next       = cmd.cmd_div;
                    loop_mode_next = (cmd.cmd_op == OP_START_LOOP);
                    loop_next      = '0;
                    state_next     = CLEAR;
                end
            end

            CLEAR: begin
                cnt_clr    = 1'b1;
                pre_next   = '0;
                state_next = RUN;
            end

            RUN: begin
                pre_next = tick ? '0 : pre_reg + 1'b1;
                if (terminal) begin
                    if (loop_mode_reg) begin
                        cnt_clr   = 1'b1;
                        loop_next = loop_reg + 1'b1;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end else if (tick) begin
                    cnt_inc = 1'b1;
                end
                // A once-mode completion outranks any command in the same cycle.
                if (state_next == RUN && accept) begin
                    if (cmd.cmd_op == OP_PAUSE_TOGGLE) begin
                        state_next = PAUSE;
                    end else if (cmd.cmd_op == OP_ABORT) begin
                        state_next = IDLE;
                    end
                end
            end

            PAUSE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_PAUSE_TOGGLE) begin
                        state_next = RUN;
                    end else if (cmd.cmd_op == OP_ABORT) begin
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pre_reg       <= '0;
            loop_reg      <= '0;
            limit_reg     <= '0;
            div_reg       <= '0;
            loop_mode_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pre_reg       <= pre_next;
            loop_reg      <= loop_next;
            limit_reg     <= limit_next;
            div_reg       <= div_next;
            loop_mode_reg <= loop_mode_next;
        end
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: directed scenarios then random commands, checked
// each cycle against an arithmetic model of run progress.
module tb_count_seq_ctrl;
    localparam int WIDTH  = 4;
    localparam int DIV_W  = 8;
    localparam int LOOP_W = 8;

    localparam logic [1:0] S_ONCE = 2'b00;
    localparam logic [1:0] S_LOOP = 2'b01;
    localparam logic [1:0] P_TOG  = 2'b10;
    localparam logic [1:0] ABRT   = 2'b11;

    localparam int M_IDLE = 0, M_CLEAR = 1, M_RUN = 2, M_PAUSE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [WIDTH-1:0]  cnt_value;
    logic              cnt_clr, cnt_inc, busy, paused, done;
    logic [LOOP_W-1:0] loop_count;
    logic              tb_cnt_init;

    count_seq_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) cmd_bus ();

    count_seq_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .LOOP_W(LOOP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_bus.slave),
        .cnt_value  (cnt_value),
        .cnt_clr    (cnt_clr),
        .cnt_inc    (cnt_inc),
        .busy       (busy),
        .paused     (paused),
        .done       (done),
        .loop_count (loop_count)
    );

    // The attached 4-bit counter datapath.
    always @(posedge clk) begin
        if (cnt_clr || tb_cnt_init) cnt_value <= '0;
        else if (cnt_inc)           cnt_value <= cnt_value + 1'b1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    // Model: progress is the number of RUN cycles since the clear.
    int m_state = M_IDLE;
    int m_r = 0, m_lim = 0, m_div = 0, m_loops = 0, m_hold = 0;
    bit m_loop = 1'b0;
    bit m_known = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r_in, input bit v, input logic [1:0] op, input int lim, input int dv);
        int per, k, val, val_after;
        bit tk, term, e_clr, e_inc, e_done, e_ready, acc;
        rst                = r_in;
        cmd_bus.cmd_valid  = v;
        cmd_bus.cmd_op     = op;
        cmd_bus.cmd_limit  = lim[WIDTH-1:0];
        cmd_bus.cmd_div    = dv[DIV_W-1:0];
        #1;
        if (done === 1'b1) last_done_cyc = cyc;
        if (m_known) begin
            per  = m_div + 1;
            k    = m_r / per;
            val  = k % (m_lim + 1);
            tk   = (m_state == M_RUN) && ((m_r % per) == m_div);
            term = tk && (val == m_lim);
            e_clr   = (m_state == M_CLEAR) || (term && m_loop);
            e_inc   = tk && !term;
            e_done  = term && !m_loop;
            e_ready = !r_in && (m_state != M_CLEAR);
            chk("cnt_clr",    {31'd0, cnt_clr}, {31'd0, e_clr});
            chk("cnt_inc",    {31'd0, cnt_inc}, {31'd0, e_inc});
            chk("done",       {31'd0, done},    {31'd0, e_done});
            chk("busy",       {31'd0, busy},    {31'd0, m_state != M_IDLE});
            chk("paused",     {31'd0, paused},  {31'd0, m_state == M_PAUSE});
            chk("cmd_ready",  {31'd0, cmd_bus.cmd_ready}, {31'd0, e_ready});
            chk("loop_count", {24'd0, loop_count}, m_loops);
            if (m_state == M_RUN || m_state == M_PAUSE)
                chk("cnt_value", {28'd0, cnt_value}, val);
            else
                chk("cnt_value", {28'd0, cnt_value}, m_hold);

            acc = v && e_ready;
            if (m_state == M_RUN || m_state == M_PAUSE)
                val_after = e_inc ? val + 1 : (e_clr ? 0 : val);
            else
                val_after = (m_state == M_CLEAR) ? 0 : m_hold;

            if (r_in) begin
                m_state = M_IDLE; m_loops = 0; m_lim = 0; m_div = 0; m_loop = 0;
                m_hold  = val_after;
            end else begin
                case (m_state)
                    M_IDLE: if (acc && !op[1]) begin
                        m_lim = lim & 15; m_div = dv & 255; m_loop = op[0];
                        m_loops = 0; m_state = M_CLEAR;
                    end
                    M_CLEAR: begin m_r = 0; m_state = M_RUN; end
                    M_RUN: begin
                        m_r++;
                        if (term) begin
                            if (!m_loop) begin m_state = M_IDLE; m_hold = m_lim; end
                            else m_loops = (m_loops + 1) % 256;
                        end
                        if (m_state == M_RUN && acc) begin
                            if (op == P_TOG) m_state = M_PAUSE;
                            else if (op == ABRT) begin m_state = M_IDLE; m_hold = val_after; end
                        end
                    end
                    default: if (acc) begin
                        if (op == P_TOG) m_state = M_RUN;
                        else if (op == ABRT) begin m_state = M_IDLE; m_hold = val; end
                    end
                endcase
            end
        end else if (r_in) begin
            m_state = M_IDLE; m_loops = 0; m_hold = 0; m_known = 1'b1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, S_ONCE, 0, 0);
    endtask

    task automatic wait_done(input int acc_cyc, output int lat);
        for (int i = 0; i < 400 && last_done_cyc < acc_cyc; i++) idle(1);
        lat = (last_done_cyc >= acc_cyc) ? last_done_cyc - acc_cyc : -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc, lat, base;
        rst = 1'b1; tb_cnt_init = 1'b1;
        cmd_bus.cmd_valid = 0; cmd_bus.cmd_op = 0; cmd_bus.cmd_limit = 0; cmd_bus.cmd_div = 0;
        @(negedge clk);
        step(1, 0, S_ONCE, 0, 0);
        step(1, 0, S_ONCE, 0, 0);
        tb_cnt_init = 1'b0;
        idle(2);

        // Once, limit 3, div 0.
        acc_cyc = cyc; step(0, 1, S_ONCE, 3, 0);
        wait_done(acc_cyc, lat);
        chk("once_l3_latency", lat, 5);
        idle(3);
        chk("once_l3_hold", {28'd0, cnt_value}, 3);

        // Loop, limit 2, div 1, no done expected.
        last_done_cyc = -1;
        step(0, 1, S_LOOP, 2, 1);
        idle(20);
        chk("loop_no_done", last_done_cyc, -1);
        chk("loop_count_20", {24'd0, loop_count}, 3);
        step(0, 1, ABRT, 0, 0);
        idle(2);

        // Once, limit 5, div 3: baseline, then paused for 10 cycles.
        acc_cyc = cyc; step(0, 1, S_ONCE, 5, 3);
        wait_done(acc_cyc, base);
        chk("once_l5d3_latency", base, 25);
        idle(2);
        acc_cyc = cyc; step(0, 1, S_ONCE, 5, 3);
        for (int i = 0; i < 100 && cnt_value != 4'd2; i++) idle(1);
        step(0, 1, P_TOG, 0, 0);
        idle(9);
        chk("paused_flag", {31'd0, paused}, 1);
        step(0, 1, P_TOG, 0, 0);
        wait_done(acc_cyc, lat);
        chk("pause_latency", lat, base + 10);
        idle(2);

        // Abort at value 4 with limit 9.
        last_done_cyc = -1;
        step(0, 1, S_ONCE, 9, 3);
        for (int i = 0; i < 100 && cnt_value != 4'd4; i++) idle(1);
        step(0, 1, ABRT, 0, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        idle(3);
        chk("abort_no_done", last_done_cyc, -1);
        chk("abort_hold", {28'd0, cnt_value}, 4);
        step(0, 1, S_ONCE, 1, 0);
        chk("restart_clr", {31'd0, cnt_clr}, 1);
        idle(6);

        // limit 0, then START while busy is ignored.
        acc_cyc = cyc; step(0, 1, S_ONCE, 0, 0);
        wait_done(acc_cyc, lat);
        chk("once_l0_latency", lat, 2);
        idle(1);
        acc_cyc = cyc; step(0, 1, S_ONCE, 2, 1);
        idle(2);
        step(0, 1, S_ONCE, 15, 9);
        wait_done(acc_cyc, lat);
        chk("start_busy_dropped", lat, 7);
        idle(2);

        // Reset in the middle of a loop run.
        step(0, 1, S_LOOP, 1, 0);
        for (int i = 0; i < 100 && loop_count != 8'd3; i++) idle(1);
        step(1, 0, S_ONCE, 0, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_loop_count", {24'd0, loop_count}, 0);
        idle(2);

        // Random command traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), $urandom_range(0, 2) != 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 3));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
